// File: rtl/micro_sequencer.sv
// Fetch/execute sequencer: T-state counter plus opcode decode to datapath strobes.
// Latency: controls are combinational from the current T-state, opcode and flags. The state advances one step per step_en edge.
// Backpressure: step_en=0 freezes the state, so every strobe holds. HALTED ignores step_en until reset.
module micro_sequencer #(
    parameter int LAST_T = 4
) (
    input  logic       clk,
    input  logic       res,
    input  logic       step_en,
    input  logic [7:0] inst,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       mem,
    output logic       ram,
    output logic       instIn,
    output logic       regA,
    output logic       regB,
    output logic       sub,
    output logic       disp,
    output logic       inc,
    output logic       progC,
    output logic       flag,
    output logic       halt,
    output logic [2:0] bus_sel,
    output logic [2:0] tstate
);

    typedef enum logic [2:0] {
        T0     = 3'd0,
        T1     = 3'd1,
        T2     = 3'd2,
        T3     = 3'd3,
        T4     = 3'd4,
        HALTED = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic       halt_q, halt_d;
    logic [3:0] op;
    state_t     last_t;

    // The operand nibble is consumed by the datapath, not by the sequencer.
    logic unused_operand;
    assign unused_operand = ^inst[3:0];

    assign op     = inst[7:4];
    assign tstate = state_q;

    // Final T-state of each opcode. Unknown opcodes end after fetch, like NOP.
    always_comb begin
        last_t = T1;
        case (op)
            4'h1, 4'h4:                      last_t = T3;
            4'h2, 4'h3:                      last_t = state_t'(3'(LAST_T));
            4'h5, 4'h6, 4'h7, 4'h8,
            4'hE, 4'hF:                      last_t = T2;
            default:                         last_t = T1;
        endcase
    end

    // Next-state logic. At T1 the NOP-length decision uses inst as presented, so NOP and unknown opcodes finish in two steps.
    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        if (step_en && state_q != HALTED) begin
            if (state_q == T2 && op == 4'hF) begin
                state_d = HALTED;
                halt_d  = 1'b1;
            end else if (state_q != T0 && state_q == last_t) begin
                state_d = T0;
            end else begin
                state_d = state_t'(state_q + 3'd1);
            end
        end
    end

    // Sequencer state and sticky halt. Reset has priority over step_en.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= T0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    // Control decode. Every line is inactive unless the current step names it.
    always_comb begin
        mem     = 1'b0;
        ram     = 1'b0;
        instIn  = 1'b0;
        regA    = 1'b0;
        regB    = 1'b0;
        sub     = 1'b0;
        disp    = 1'b0;
        inc     = 1'b0;
        progC   = 1'b0;
        flag    = 1'b0;
        halt    = halt_q;
        bus_sel = 3'd7;
        case (state_q)
            T0: begin
                bus_sel = 3'd1;
                mem     = 1'b1;
            end
            T1: begin
                bus_sel = 3'd0;
                instIn  = 1'b1;
                inc     = 1'b1;
            end
            T2: begin
                case (op)
                    4'h1, 4'h2, 4'h3, 4'h4: begin bus_sel = 3'd2; mem   = 1'b1; end
                    4'h5:                   begin bus_sel = 3'd2; regA  = 1'b1; end
                    4'h6:                   begin bus_sel = 3'd2; progC = 1'b1; end
                    4'h7: if (carry_flag)   begin bus_sel = 3'd2; progC = 1'b1; end
                    4'h8: if (zero_flag)    begin bus_sel = 3'd2; progC = 1'b1; end
                    4'hE:                   begin bus_sel = 3'd3; disp  = 1'b1; end
                    4'hF:                   halt = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                case (op)
                    4'h1: begin bus_sel = 3'd0; regA = 1'b1; end
                    4'h2: begin bus_sel = 3'd0; regB = 1'b1; end
                    4'h3: begin bus_sel = 3'd0; regB = 1'b1; sub = 1'b1; end
                    4'h4: begin bus_sel = 3'd3; ram  = 1'b1; end
                    default: ;
                endcase
            end
            T4: begin
                case (op)
                    4'h2: begin bus_sel = 3'd5; regA = 1'b1; flag = 1'b1; end
                    4'h3: begin bus_sel = 3'd5; regA = 1'b1; flag = 1'b1; sub = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: each opcode's T-state walk, stalls, flags, halt and reset.
// Inputs are driven on falling edges; outputs are sampled on falling edges.
// Expected values are hand-written constants.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       step_en = 1'b0;
    logic [7:0] inst = 8'h00;
    logic       carry_flag = 1'b0;
    logic       zero_flag = 1'b0;
    logic       mem, ram, instIn, regA, regB, sub, disp, inc, progC, flag, halt;
    logic [2:0] bus_sel, tstate;

    int total = 0;
    int bad   = 0;

    // Control vector bit positions: {mem,ram,instIn,regA,regB,sub,disp,inc,progC,flag,halt}
    localparam logic [10:0] C_NONE = 11'h000;
    localparam logic [10:0] C_MEM  = 11'h400;
    localparam logic [10:0] C_RAM  = 11'h200;
    localparam logic [10:0] C_IR   = 11'h100;
    localparam logic [10:0] C_A    = 11'h080;
    localparam logic [10:0] C_B    = 11'h040;
    localparam logic [10:0] C_SUB  = 11'h020;
    localparam logic [10:0] C_DISP = 11'h010;
    localparam logic [10:0] C_INC  = 11'h008;
    localparam logic [10:0] C_PC   = 11'h004;
    localparam logic [10:0] C_FLAG = 11'h002;
    localparam logic [10:0] C_HALT = 11'h001;

    logic [10:0] ctl;
    assign ctl = {mem, ram, instIn, regA, regB, sub, disp, inc, progC, flag, halt};

    micro_sequencer #(.LAST_T(4)) dut (
        .clk(clk), .res(res), .step_en(step_en), .inst(inst),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .mem(mem), .ram(ram), .instIn(instIn), .regA(regA), .regB(regB),
        .sub(sub), .disp(disp), .inc(inc), .progC(progC), .flag(flag),
        .halt(halt), .bus_sel(bus_sel), .tstate(tstate)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_st(input string tag, input logic [2:0] ts, input logic [10:0] c, input logic [2:0] bs);
        check({tag, ".tstate"},  32'(tstate),  32'(ts));
        check({tag, ".ctl"},     32'(ctl),     32'(c));
        check({tag, ".bus_sel"}, 32'(bus_sel), 32'(bs));
    endtask

    // One enabled clock edge; the new state is visible at the following falling edge.
    task automatic step();
        @(negedge clk) step_en = 1'b1;
        @(negedge clk) step_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) res = 1'b0;
        @(negedge clk) res = 1'b1;
    endtask

    // Walks an instruction through fetch so the caller lands in T2.
    task automatic fetch(input string tag);
        expect_st({tag, ".T0"}, 3'd0, C_MEM, 3'd1);
        step();
        expect_st({tag, ".T1"}, 3'd1, C_IR | C_INC, 3'd0);
        step();
    endtask

    // Opcodes that finish in T2: opcode, expected T2 controls and bus source
    logic [7:0]  s3_op  [5] = '{8'h51, 8'h63, 8'hE0, 8'h75, 8'h85};
    logic [10:0] s3_ctl [5] = '{C_A, C_PC, C_DISP, C_PC, C_PC};
    logic [2:0]  s3_bs  [5] = '{3'd2, 3'd2, 3'd3, 3'd2, 3'd2};

    initial begin
        repeat (3) @(negedge clk);
        res = 1'b1;
        // Reset state is the T0 decode
        expect_st("reset", 3'd0, C_MEM, 3'd1);

        // NOP: two steps and back to T0
        inst = 8'h00;
        fetch("nop");
        expect_st("nop.end", 3'd0, C_MEM, 3'd1);

        // ADD
        inst = 8'h2A;
        fetch("add");
        expect_st("add.T2", 3'd2, C_MEM, 3'd2);
        step();
        expect_st("add.T3", 3'd3, C_B, 3'd0);
        step();
        expect_st("add.T4", 3'd4, C_A | C_FLAG, 3'd5);
        step();
        expect_st("add.end", 3'd0, C_MEM, 3'd1);

        // SUB
        inst = 8'h3A;
        fetch("sub");
        expect_st("sub.T2", 3'd2, C_MEM, 3'd2);
        step();
        expect_st("sub.T3", 3'd3, C_B | C_SUB, 3'd0);
        step();
        expect_st("sub.T4", 3'd4, C_A | C_FLAG | C_SUB, 3'd5);
        step();
        expect_st("sub.end", 3'd0, C_MEM, 3'd1);

        // STA
        inst = 8'h47;
        fetch("sta");
        expect_st("sta.T2", 3'd2, C_MEM, 3'd2);
        step();
        expect_st("sta.T3", 3'd3, C_RAM, 3'd3);
        step();
        expect_st("sta.end", 3'd0, C_MEM, 3'd1);

        // LDI, JMP, OUT, and taken JC/JZ
        carry_flag = 1'b1;
        zero_flag  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inst = s3_op[i];
            fetch($sformatf("op%02h", s3_op[i]));
            expect_st($sformatf("op%02h.T2", s3_op[i]), 3'd2, s3_ctl[i], s3_bs[i]);
            step();
            expect_st($sformatf("op%02h.end", s3_op[i]), 3'd0, C_MEM, 3'd1);
        end

        // JC and JZ: a flag dropping mid-T2 removes the jump for that step
        inst = 8'h75;
        fetch("jc");
        expect_st("jc.taken", 3'd2, C_PC, 3'd2);
        @(negedge clk) carry_flag = 1'b0;
        #1 expect_st("jc.nottaken", 3'd2, C_NONE, 3'd7);
        step();
        expect_st("jc.end", 3'd0, C_MEM, 3'd1);
        inst = 8'h85;
        fetch("jz");
        expect_st("jz.taken", 3'd2, C_PC, 3'd2);
        @(negedge clk) zero_flag = 1'b0;
        #1 expect_st("jz.nottaken", 3'd2, C_NONE, 3'd7);
        step();
        expect_st("jz.end", 3'd0, C_MEM, 3'd1);

        // Illegal opcode behaves as NOP
        inst = 8'hB3;
        fetch("ill");
        expect_st("ill.end", 3'd0, C_MEM, 3'd1);

        // LDA stalled in T3, then reset arriving together with step_en
        inst = 8'h1C;
        fetch("lda");
        expect_st("lda.T2", 3'd2, C_MEM, 3'd2);
        step();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            expect_st($sformatf("lda.stall%0d", i), 3'd3, C_A, 3'd0);
        end
        @(negedge clk) begin res = 1'b0; step_en = 1'b1; end
        @(negedge clk) begin res = 1'b1; step_en = 1'b0; end
        expect_st("lda.midreset", 3'd0, C_MEM, 3'd1);

        // HLT: halt at T2, then HALTED ignores step_en
        inst = 8'hF0;
        fetch("hlt");
        expect_st("hlt.T2", 3'd2, C_HALT, 3'd7);
        step();
        expect_st("hlt.halted", 3'd7, C_HALT, 3'd7);
        for (int i = 0; i < 10; i++) begin
            step();
            expect_st($sformatf("hlt.hold%0d", i), 3'd7, C_HALT, 3'd7);
        end
        do_reset();
        expect_st("hlt.reset", 3'd0, C_MEM, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
